// File: rtl/uart_rx_if.sv
// UART receive port bundle: serial line and sample strobe in, frame results out.
// Latency: none (wiring only).
// Backpressure: none; results are pulses with no consumer handshake.
//
// Signals:
//   RxD        serial line, idle high, asynchronous to clk
//   SampleTick one-clk strobe at OVERSAMPLE x baud
//   RxD_data   last good frame payload, LSB first on the wire
//   RxD_valid  one-clk pulse when RxD_data is updated
//   Frame_err  one-clk pulse when a stop bit is sampled low
//   Busy       receiver is inside a frame
interface uart_rx_if #(
    parameter int BITS = 8
);
    logic            RxD;
    logic            SampleTick;
    logic [BITS-1:0] RxD_data;
    logic            RxD_valid;
    logic            Frame_err;
    logic            Busy;

    // Driver side: the line and the tick source.
    modport master (
        output RxD,
        output SampleTick,
        input  RxD_data,
        input  RxD_valid,
        input  Frame_err,
        input  Busy
    );

    // Receiver side.
    modport slave (
        input  RxD,
        input  SampleTick,
        output RxD_data,
        output RxD_valid,
        output Frame_err,
        output Busy
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampled UART receiver: synchronises RxD, finds mid start bit, shifts BITS data bits LSB-first, checks stop bit.
// Latency: result pulse one clk after the mid-stop-bit sample (~2 sync + OVERSAMPLE/2 + OVERSAMPLE*(BITS+1) ticks from start edge).
// Backpressure: none; RxD_data is simply overwritten by each good frame.
//
// Ports: clk (rising edge), rst (synchronous, active-high),
//        bus (uart_rx_if.slave): RxD, SampleTick in; RxD_data, RxD_valid, Frame_err, Busy out.
module uart_rx #(
    parameter int BITS       = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(BITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [BITS-1:0] shift_q, shift_d;
    logic [BITS-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    // Set after a bad stop bit: hold in STOP until the line returns high,
    // so a long break reports only one framing error.
    logic            err_wait_q, err_wait_d;
    logic            rxd_meta_q, rxd_s_q;
    logic [BITS:0]   shift_in;

    assign shift_in = {rxd_s_q, shift_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            err_wait_q <= 1'b0;
        end else begin
            rxd_meta_q <= bus.RxD;
            rxd_s_q    <= rxd_meta_q;
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            err_wait_q <= err_wait_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        err_wait_d = err_wait_q;

        case (state_q)
            IDLE: begin
                // Start-edge detection runs every clk, independent of SampleTick.
                if (!rxd_s_q) begin
                    state_d = START;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            end

            START: begin
                if (bus.SampleTick) begin
                    if (tick_q == TICK_MID) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        // Line back high at mid start bit means it was a glitch.
                        state_d = rxd_s_q ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end

            DATA: begin
                if (bus.SampleTick) begin
                    if (tick_q == TICK_LAST) begin
                        shift_d = shift_in[BITS:1];
                        tick_d  = '0;
                        bit_d   = bit_q + BW'(1);
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                            bit_d   = '0;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end

            STOP: begin
                if (err_wait_q) begin
                    if (rxd_s_q) begin
                        state_d    = IDLE;
                        err_wait_d = 1'b0;
                        tick_d     = '0;
                    end
                end else if (bus.SampleTick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (rxd_s_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d     = 1'b1;
                            err_wait_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
        endcase
    end

    assign bus.RxD_data  = data_q;
    assign bus.RxD_valid = valid_q;
    assign bus.Frame_err = ferr_q;
    assign bus.Busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
    localparam int OS = 16;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         div;
        int         gap;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    logic clk;
    logic rst;

    uart_rx_if #(.BITS(8)) bus ();

    uart_rx #(.BITS(8), .OVERSAMPLE(OS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         valid_cyc = 0;
    int         tick_div = 1;
    int         tick_phase = 0;
    logic       tick_seen = 1'b0;
    logic       prev_pulse = 1'b0;
    logic [7:0] last_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Advance one clock; observe outputs at the falling edge, then schedule the next SampleTick.
    task automatic step();
        logic rst_at_edge;
        exp_t e;
        @(posedge clk);
        cyc++;
        tick_seen   = bus.SampleTick;
        rst_at_edge = rst;
        @(negedge clk);
        if (rst_at_edge) last_data = 8'h00;
        if (bus.RxD_valid || bus.Frame_err) begin
            checks++;
            if ((bus.RxD_valid && bus.Frame_err) || prev_pulse) begin
                errors++;
                $display("FAIL pulse_excl valid=%b ferr=%b prev=%b", bus.RxD_valid, bus.Frame_err, prev_pulse);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse valid=%b ferr=%b data=%02h", bus.RxD_valid, bus.Frame_err, bus.RxD_data);
            end else begin
                e = sb.pop_front();
                if (e.is_err ? !bus.Frame_err : (!bus.RxD_valid || bus.RxD_data !== e.data)) begin
                    errors++;
                    $display("FAIL sb_pulse got valid=%b ferr=%b data=%02h want err=%b data=%02h",
                             bus.RxD_valid, bus.Frame_err, bus.RxD_data, e.is_err, e.data);
                end
                if (!e.is_err) last_data = e.data;
            end
            if (bus.RxD_valid) begin
                n_valid++;
                valid_cyc = cyc;
            end
            if (bus.Frame_err) n_ferr++;
        end else begin
            checks++;
            if (bus.RxD_data !== last_data) begin
                errors++;
                $display("FAIL data_hold got %02h want %02h", bus.RxD_data, last_data);
            end
        end
        prev_pulse = bus.RxD_valid || bus.Frame_err;
        if (tick_phase >= tick_div - 1) begin
            bus.SampleTick = 1'b1;
            tick_phase     = 0;
        end else begin
            bus.SampleTick = 1'b0;
            tick_phase++;
        end
    endtask

    task automatic wait_ticks(input int n);
        int c = 0;
        while (c < n) begin
            step();
            if (tick_seen) c++;
        end
    endtask

    // Transmitter model: each bit lasts exactly OS SampleTicks (BaudTick every OS-th tick).
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic push,
                              input logic exp_err, input logic [7:0] exp_data);
        exp_t e;
        if (push) begin
            e.is_err = exp_err;
            e.data   = exp_data;
            sb.push_back(e);
        end
        bus.RxD = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 8; i++) begin
            bus.RxD = d[i];
            wait_ticks(OS);
        end
        bus.RxD = stop;
        wait_ticks(OS);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending %0d want 0", name, sb.size());
            sb.delete();
        end
    endtask

    vec_t vecs[7];

    initial begin
        int t0;
        int v0;
        int f0;
        int lat;
        logic [7:0] b;
        logic [7:0] part;

        vecs[0] = '{8'h00, 1'b1, 1, 2, 1'b0, 8'h00};
        vecs[1] = '{8'hFF, 1'b1, 1, 0, 1'b0, 8'hFF};
        vecs[2] = '{8'h55, 1'b1, 3, 1, 1'b0, 8'h55};
        vecs[3] = '{8'h01, 1'b1, 2, 0, 1'b0, 8'h01};
        vecs[4] = '{8'h80, 1'b1, 1, 1, 1'b0, 8'h80};
        vecs[5] = '{8'h77, 1'b0, 1, 1, 1'b1, 8'h00};
        vecs[6] = '{8'hC3, 1'b1, 1, 1, 1'b0, 8'hC3};

        rst            = 1'b1;
        bus.RxD        = 1'b1;
        bus.SampleTick = 1'b0;
        repeat (3) step();
        chk("rst_data", 32'(bus.RxD_data), 32'h00);
        chk("rst_valid", 32'(bus.RxD_valid), 32'h0);
        chk("rst_ferr", 32'(bus.Frame_err), 32'h0);
        chk("rst_busy", 32'(bus.Busy), 32'h0);
        rst = 1'b0;
        repeat (10) step();

        // Good frame 0xA5 with latency from start edge to valid pulse.
        t0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5);
        drain("a5", 200);
        lat = valid_cyc - t0;
        checks++;
        if (lat < 153 || lat > 155) begin
            errors++;
            $display("FAIL a5_latency got %0d want 154+/-1", lat);
        end
        chk("a5_nvalid", 32'(n_valid), 32'd1);
        chk("a5_nferr", 32'(n_ferr), 32'd0);
        repeat (10) step();
        chk("a5_idle", 32'(bus.Busy), 32'h0);

        // Start-bit glitch: 4 ticks low then high.
        v0 = n_valid;
        f0 = n_ferr;
        bus.RxD = 1'b0;
        wait_ticks(4);
        bus.RxD = 1'b1;
        repeat (40) step();
        chk("glitch_busy", 32'(bus.Busy), 32'h0);
        chk("glitch_valid", 32'(n_valid - v0), 32'd0);
        chk("glitch_ferr", 32'(n_ferr - f0), 32'd0);
        chk("glitch_data", 32'(bus.RxD_data), 32'hA5);

        // Bad stop bit followed by a 40-bit-time break.
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 8'h00);
        wait_ticks(OS * 40);
        chk("brk_busy", 32'(bus.Busy), 32'h1);
        chk("brk_nferr", 32'(n_ferr - f0), 32'd1);
        chk("brk_data", 32'(bus.RxD_data), 32'hA5);
        bus.RxD = 1'b1;
        repeat (5) step();
        chk("brk_release", 32'(bus.Busy), 32'h0);
        drain("brk", 10);

        // Table: back-to-back, slowed SampleTick, bad stop, edge payloads.
        v0 = n_valid;
        for (int i = 0; i < 7; i++) begin
            tick_div = vecs[i].div;
            wait_ticks(vecs[i].gap * OS);
            send_frame(vecs[i].data, vecs[i].stop, 1'b1, vecs[i].exp_err, vecs[i].exp_data);
            if (!vecs[i].stop) bus.RxD = 1'b1;
        end
        drain("table", 2000);
        chk("table_nvalid", 32'(n_valid - v0), 32'd6);
        tick_div = 1;
        repeat (10) step();

        // Reset in the middle of DATA after four bits.
        part = 8'h5A;
        bus.RxD = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 4; i++) begin
            bus.RxD = part[i];
            wait_ticks(OS);
        end
        chk("mid_busy_pre", 32'(bus.Busy), 32'h1);
        rst = 1'b1;
        step();
        chk("mid_rst_data", 32'(bus.RxD_data), 32'h00);
        chk("mid_rst_valid", 32'(bus.RxD_valid), 32'h0);
        chk("mid_rst_ferr", 32'(bus.Frame_err), 32'h0);
        chk("mid_rst_busy", 32'(bus.Busy), 32'h0);
        rst = 1'b0;
        bus.RxD = 1'b1;
        repeat (20) step();
        send_frame(8'h81, 1'b1, 1'b1, 1'b0, 8'h81);
        drain("post_rst", 200);
        chk("post_rst_data", 32'(bus.RxD_data), 32'h81);

        // Continuous stream from the transmitter model.
        v0 = n_valid;
        f0 = n_ferr;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1, 1'b1, 1'b0, b);
        end
        drain("loop", 200);
        chk("loop_nvalid", 32'(n_valid - v0), 32'd256);
        chk("loop_nferr", 32'(n_ferr - f0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
